fp_addsub_unit: RTL and testbench
=================================

# fp_addsub_unit

Multi-cycle IEEE-754 binary32 adder/subtractor for the Execute stage of the pipelined RISC-V core. It implements FADD.S and FSUB.S. The unit takes operands already forwarded from the FP register file path, holds busy_o so the hazard unit stalls F/D/E, and returns a rounded result with exception flags toward the E/M pipeline register. Rounding is fixed round-to-nearest-even; subnormals are flushed to zero.

## Interface
Parameters:
- LATENCY, 5, cycles from the accepting edge to the valid_o cycle; fixed, not configurable in RTL beyond documentation.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- start_i  in  1  request; sampled only when busy_o=0
- flush_i  in  1  FlushE from the hazard unit; aborts the operation in flight
- op_sub_i  in  1  1 = a-b, 0 = a+b; sampled with start_i
- a_i  in  32  operand A, binary32
- b_i  in  32  operand B, binary32
- busy_o  out  1  operation in flight; drives the stall request
- valid_o  out  1  one-cycle pulse, result_o/flags_o valid
- result_o  out  32  binary32 result; holds until the next valid_o
- flags_o  out  5  {NV, DZ, OF, UF, NX}; DZ is always 0

## Operation
- States: IDLE → UNPACK → ALIGN → ADD → NORM → ROUND → IDLE.
- IDLE + start_i=1: latch the operands and op_sub_i, then go to UNPACK. A start_i while busy is ignored.
- UNPACK:
  - Split sign, exponent and mantissa; apply the hidden 1.
  - A zero-exponent input becomes a signed zero (no flag).
  - Effective sign of B = b[31] XOR op_sub.
  - Classify NaN and inf.
- ALIGN:
  - Swap operands so the larger magnitude is first.
  - Right-shift the smaller mantissa by the exponent difference into a 27-bit field (24 + guard, round, sticky).
  - Shifts ≥ 27 collapse to the sticky bit.
- ADD: 28-bit add or subtract of the magnitudes. The result sign is the larger operand's sign.
- NORM:
  - On carry-out, shift right 1 and OR the lost bit into sticky; exp+1.
  - Otherwise left-shift by the leading-zero count (priority encoder, single cycle) and reduce exp.
- ROUND:
  - RNE: increment when G & (R | S | lsb).
  - A mantissa overflow after the increment bumps exp.
  - NX = G | R | S.
- Specials, resolved in ROUND and taking priority:
  - Any NaN input, or inf − inf: result 0x7FC00000, NV=1.
  - inf ± finite: that inf.
  - Exponent ≥ 255 after rounding: signed inf, OF=1, NX=1.
  - Nonzero result with exponent < 1 after rounding: signed zero, UF=1, NX=1.
  - Exact zero from cancellation: +0. (−0)+(−0) gives −0.
- Flags that do not apply are 0. The sNaN/qNaN distinction is not made.

## Timing
- Reset (reset=0 at an edge) forces:
  - state=IDLE, busy_o=0, valid_o=0
  - result_o=0x00000000, flags_o=5'b0
  - Reset mid-operation discards the operation; no valid_o.
- Accept at edge N, then:
  - busy_o is 1 from edge N until edge N+5.
  - valid_o is 1 for exactly the cycle following edge N+5, with busy_o=0 in that cycle.
  - A start_i in the valid_o cycle is accepted (back-to-back, 5-cycle throughput).
- flush_i=1 at an edge:
  - The state returns to IDLE and busy_o=0 after that edge. No valid_o is produced; result_o and flags_o are unchanged.
  - flush_i has priority over start_i at the same edge: the start is dropped.
  - A flush arriving together with the final (ROUND→IDLE) edge suppresses valid_o.
- result_o and flags_o update only on the edge that raises valid_o.

## Test plan
- 0x3FC00000 + 0x40100000 (1.5 + 2.25), op_sub=0:
  - result 0x40700000, flags 0.
  - valid_o exactly 5 cycles after accept.
  - busy_o high for 5 cycles.
- 0x3F800000 − 0x3F800000 → 0x00000000, flags 0. 0x80000000 + 0x80000000 → 0x80000000.
- Specials:
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, NV=1.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags 5'b00101 (OF, NX).
- Rounding:
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000, NX=1.
  - 0x3F800000 + 0x33C00000 → 0x3F800001, NX=1.
  - A subnormal input 0x00000001 + 0x3F800000 → 0x3F800000, flags 0.
- Control:
  - start_i while busy → ignored, one valid_o only.
  - flush_i 2 cycles after accept → busy_o low next cycle, no valid_o, result_o unchanged.
  - start in the valid_o cycle → second result 5 cycles later.
- reset=0 in the ADD state → all outputs at reset values. Then a new start after release → normal 5-cycle result.

Source files
------------

// File: rtl/fp_addsub_unit.sv
// Multi-cycle binary32 FADD.S/FSUB.S: RNE rounding, subnormals flushed to zero.
// Five busy cycles per op, one-cycle valid_o pulse; flush_i aborts with no result.
module fp_addsub_unit #(
  parameter int LATENCY = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic        op_sub_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic [4:0]  flags_o
);

  if (LATENCY != 5) begin : g_latency_check
    $error("fp_addsub_unit latency is fixed at 5 cycles");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND
  } state_t;

  state_t state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  flags_q, flags_d;

  // Operand latch
  logic [31:0] a_q, b_q;
  logic        op_q;

  // Unpacked operands and special-case classification
  logic [7:0]  ea_q, eb_q, ea_d, eb_d;
  logic [23:0] ma_q, mb_q, ma_d, mb_d;
  logic        sa_q, sb_q, sa_d, sb_d;
  logic        nan_q, inf_q, inf_sign_q, nan_d, inf_d, inf_sign_d;

  // Aligned magnitudes
  logic [26:0] big_q, small_q, big_d, small_d;
  logic [7:0]  exp_al_q, exp_al_d;
  logic        sign_q, sub_q, sign_d, sub_d;

  logic [27:0] sum_q, sum_d;

  logic [26:0]       nmant_q, nmant_d;
  logic signed [9:0] nexp_q, nexp_d;
  logic              zero_q, zero_d;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      result_q <= 32'h0;
      flags_q  <= 5'h0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start_i) state_d = S_UNPACK;
        S_UNPACK: state_d = S_ALIGN;
        S_ALIGN:  state_d = S_ADD;
        S_ADD:    state_d = S_NORM;
        S_NORM:   state_d = S_ROUND;
        S_ROUND:  state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o   = (state_q != S_IDLE);
    valid_o  = valid_q;
    result_o = result_q;
    flags_o  = flags_q;
  end

  // ---------------- Datapath stages ----------------
  always_comb begin
    ea_d = a_q[30:23];
    eb_d = b_q[30:23];
    ma_d = (ea_d == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
    mb_d = (eb_d == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
    sa_d = a_q[31];
    sb_d = b_q[31] ^ op_q;
    nan_d = (&ea_d && |a_q[22:0]) || (&eb_d && |b_q[22:0]) ||
            (&ea_d && ~|a_q[22:0] && &eb_d && ~|b_q[22:0] && (sa_d != sb_d));
    inf_d      = (&ea_d && ~|a_q[22:0]) || (&eb_d && ~|b_q[22:0]);
    inf_sign_d = (&ea_d && ~|a_q[22:0]) ? sa_d : sb_d;
  end

  logic        a_big;
  logic [7:0]  e_small, diff;
  logic [23:0] m_small;
  logic [26:0] full_s, shifted, lost_mask;
  always_comb begin
    a_big    = {ea_q, ma_q} >= {eb_q, mb_q};
    exp_al_d = a_big ? ea_q : eb_q;
    e_small  = a_big ? eb_q : ea_q;
    m_small  = a_big ? mb_q : ma_q;
    big_d    = {(a_big ? ma_q : mb_q), 3'b000};
    sign_d   = a_big ? sa_q : sb_q;
    sub_d    = sa_q ^ sb_q;
    diff     = exp_al_d - e_small;
    full_s   = {m_small, 3'b000};
    shifted  = full_s >> diff[4:0];
    lost_mask = ~(27'h7FF_FFFF << diff[4:0]);
    // Everything shifted past the round bit is folded into sticky
    if (diff >= 8'd27) small_d = {26'd0, |m_small};
    else               small_d = {shifted[26:1], shifted[0] | (|(full_s & lost_mask))};
  end

  always_comb begin
    sum_d = sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
  end

  logic [4:0] lzc;
  logic       found;
  always_comb begin
    lzc   = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum_q[i]) begin
        lzc   = 5'(26 - i);
        found = 1'b1;
      end
    end
    zero_d = (sum_q == 28'd0);
    if (sum_q[27]) begin
      nmant_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
      nexp_d  = $signed({2'b00, exp_al_q}) + 10'sd1;
    end else begin
      nmant_d = sum_q[26:0] << lzc;
      nexp_d  = $signed({2'b00, exp_al_q}) - $signed({5'd0, lzc});
    end
  end

  logic              g_bit, r_bit, s_bit, inc;
  logic [24:0]       rnd;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_r;
  logic [31:0]       res_w;
  logic [4:0]        flg_w;
  always_comb begin
    g_bit = nmant_q[2];
    r_bit = nmant_q[1];
    s_bit = nmant_q[0];
    inc   = g_bit & (r_bit | s_bit | nmant_q[3]);
    rnd   = {1'b0, nmant_q[26:3]} + {24'd0, inc};
    if (rnd[24]) begin
      mant_r = rnd[24:1];
      exp_r  = nexp_q + 10'sd1;
    end else begin
      mant_r = rnd[23:0];
      exp_r  = nexp_q;
    end
    if (nan_q) begin
      res_w = 32'h7FC0_0000;
      flg_w = 5'b10000;
    end else if (inf_q) begin
      res_w = {inf_sign_q, 8'hFF, 23'd0};
      flg_w = 5'b00000;
    end else if (zero_q) begin
      // Cancellation gives +0; only like-signed zeros keep their sign
      res_w = {sign_q & ~sub_q, 31'd0};
      flg_w = 5'b00000;
    end else if (exp_r >= 10'sd255) begin
      res_w = {sign_q, 8'hFF, 23'd0};
      flg_w = 5'b00101;
    end else if (exp_r < 10'sd1) begin
      res_w = {sign_q, 31'd0};
      flg_w = 5'b00011;
    end else begin
      res_w = {sign_q, exp_r[7:0], mant_r[22:0]};
      flg_w = {4'b0000, g_bit | r_bit | s_bit};
    end
  end

  always_comb begin
    valid_d  = (state_q == S_ROUND) && !flush_i;
    result_d = valid_d ? res_w : result_q;
    flags_d  = valid_d ? flg_w : flags_q;
  end

  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_q  <= a_i;
          b_q  <= b_i;
          op_q <= op_sub_i;
        end
      end
      S_UNPACK: begin
        ea_q       <= ea_d;
        eb_q       <= eb_d;
        ma_q       <= ma_d;
        mb_q       <= mb_d;
        sa_q       <= sa_d;
        sb_q       <= sb_d;
        nan_q      <= nan_d;
        inf_q      <= inf_d;
        inf_sign_q <= inf_sign_d;
      end
      S_ALIGN: begin
        big_q    <= big_d;
        small_q  <= small_d;
        exp_al_q <= exp_al_d;
        sign_q   <= sign_d;
        sub_q    <= sub_d;
      end
      S_ADD: sum_q <= sum_d;
      S_NORM: begin
        nmant_q <= nmant_d;
        nexp_q  <= nexp_d;
        zero_q  <= zero_d;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fp_addsub_unit.sv
// Self-checking bench for fp_addsub_unit: scoreboard of expected results,
// one task per scenario, outputs sampled 1 ns after the rising edge.
module tb_fp_addsub_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        flush_i;
  logic        op_sub_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  flags_o;

  fp_addsub_unit #(.LATENCY(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .op_sub_i (op_sub_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o),
    .flags_o  (flags_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  f;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_r = 32'h0;
  logic [4:0]  last_f = 5'h0;

  // Drive a request; caller is positioned just after a rising edge.
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic op);
    start_i  = 1'b1;
    a_i      = a;
    b_i      = b;
    op_sub_i = op;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // Bounded wait for valid_o; cyc = 0 means the bound expired.
  task automatic wait_valid(output logic [31:0] r, output logic [4:0] f, output int cyc);
    cyc = 0;
    r   = '0;
    f   = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (valid_o) begin
        cyc = i;
        r   = result_o;
        f   = flags_o;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_sub_i = 1'b0;
    a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", result_o); end
    checks++; if (flags_o !== 5'h0) begin errors++; $display("FAIL reset_flags: got %b want 00000", flags_o); end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add;
    sb_q.push_back('{r: 32'h4070_0000, f: 5'b00000});
    drive_start(32'h3FC0_0000, 32'h4010_0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busy_o !== 1'b1 || valid_o !== 1'b0) begin
        errors++; $display("FAIL add_busy[%0d]: busy=%b valid=%b want busy=1 valid=0", i, busy_o, valid_o);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL add_latency: valid=%b busy=%b want valid=1 busy=0", valid_o, busy_o);
    end
    e = sb_q.pop_front();
    last_r = e.r; last_f = e.f;
    checks++; if (result_o !== e.r) begin errors++; $display("FAIL add_result: got %h want %h", result_o, e.r); end
    checks++; if (flags_o !== e.f) begin errors++; $display("FAIL add_flags: got %b want %b", flags_o, e.f); end
    @(posedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL add_pulse: valid=%b want 0", valid_o); end
  endtask

  task automatic test_vectors;
    logic [31:0] va[16] = '{32'h3F80_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7F7F_FFFF,
                            32'h3F80_0000, 32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000,
                            32'h7FC0_0001, 32'h3F80_0000, 32'h0080_0001, 32'hC000_0000,
                            32'h3F80_0000, 32'h4B80_0000, 32'h3F80_0000, 32'h8000_0000};
    logic [31:0] vb[16] = '{32'h3F80_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7F7F_FFFF,
                            32'h3380_0000, 32'h33C0_0000, 32'h3F80_0000, 32'h3F80_0000,
                            32'h3F80_0000, 32'h4000_0000, 32'h0080_0000, 32'h3F80_0000,
                            32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000};
    logic        vo[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] vr[16] = '{32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h7F80_0000,
                            32'h3F80_0000, 32'h3F80_0001, 32'h3F80_0000, 32'h7F80_0000,
                            32'h7FC0_0000, 32'hBF80_0000, 32'h0000_0000, 32'hBF80_0000,
                            32'h4000_0000, 32'h4B80_0000, 32'h3F80_0000, 32'h8000_0000};
    logic [4:0]  vf[16] = '{5'b00000, 5'b00000, 5'b10000, 5'b00101,
                            5'b00001, 5'b00001, 5'b00000, 5'b00000,
                            5'b10000, 5'b00000, 5'b00011, 5'b00000,
                            5'b00000, 5'b00001, 5'b00000, 5'b00000};
    logic [31:0] r;
    logic [4:0]  f;
    int          cyc;
    for (int k = 0; k < 16; k++) begin
      sb_q.push_back('{r: vr[k], f: vf[k]});
      drive_start(va[k], vb[k], vo[k]);
      wait_valid(r, f, cyc);
      e = sb_q.pop_front();
      last_r = e.r; last_f = e.f;
      checks++; if (cyc != 5) begin errors++; $display("FAIL vec%0d_latency: got %0d want 5", k, cyc); end
      checks++; if (r !== e.r) begin errors++; $display("FAIL vec%0d_result: got %h want %h", k, r, e.r); end
      checks++; if (f !== e.f) begin errors++; $display("FAIL vec%0d_flags: got %b want %b", k, f, e.f); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_start;
    int          nvalid = 0;
    logic [31:0] r = '0;
    logic [4:0]  f = '0;
    sb_q.push_back('{r: 32'h4070_0000, f: 5'b00000});
    drive_start(32'h3FC0_0000, 32'h4010_0000, 1'b0);
    @(posedge clk); #1;
    drive_start(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (valid_o) begin
        nvalid++;
        if (nvalid == 1) begin r = result_o; f = flags_o; end
      end
    end
    e = sb_q.pop_front();
    last_r = e.r; last_f = e.f;
    checks++; if (nvalid != 1) begin errors++; $display("FAIL busy_start_count: got %0d valids want 1", nvalid); end
    checks++; if (r !== e.r) begin errors++; $display("FAIL busy_start_result: got %h want %h", r, e.r); end
    checks++; if (f !== e.f) begin errors++; $display("FAIL busy_start_flags: got %b want %b", f, e.f); end
  endtask

  task automatic test_flush;
    int nvalid = 0;
    drive_start(32'h3F80_0000, 32'h4000_0000, 1'b0);
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy_o); end
    // Start and flush on the same edge: the start is dropped
    start_i = 1'b1; flush_i = 1'b1; a_i = 32'h3F80_0000; b_i = 32'h3F80_0000; op_sub_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b want 0", busy_o); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (valid_o) nvalid++;
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL flush_valid: got %0d valids want 0", nvalid); end
    checks++; if (result_o !== last_r) begin errors++; $display("FAIL flush_result: got %h want %h", result_o, last_r); end
    checks++; if (flags_o !== last_f) begin errors++; $display("FAIL flush_flags: got %b want %b", flags_o, last_f); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    logic [4:0]  f;
    int          cyc;
    sb_q.push_back('{r: 32'h40A0_0000, f: 5'b00000});
    sb_q.push_back('{r: 32'h4110_0000, f: 5'b00000});
    drive_start(32'h4000_0000, 32'h4040_0000, 1'b0);
    wait_valid(r, f, cyc);
    e = sb_q.pop_front();
    checks++; if (cyc != 5) begin errors++; $display("FAIL b2b_first_latency: got %0d want 5", cyc); end
    checks++; if (r !== e.r || f !== e.f) begin errors++; $display("FAIL b2b_first: got %h/%b want %h/%b", r, f, e.r, e.f); end
    drive_start(32'h4120_0000, 32'h3F80_0000, 1'b1);
    wait_valid(r, f, cyc);
    e = sb_q.pop_front();
    last_r = e.r; last_f = e.f;
    checks++; if (cyc != 5) begin errors++; $display("FAIL b2b_second_latency: got %0d want 5", cyc); end
    checks++; if (r !== e.r || f !== e.f) begin errors++; $display("FAIL b2b_second: got %h/%b want %h/%b", r, f, e.r, e.f); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int nvalid = 0;
    drive_start(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    last_r = 32'h0; last_f = 5'h0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", valid_o); end
    checks++; if (result_o !== last_r) begin errors++; $display("FAIL mid_reset_result: got %h want %h", result_o, last_r); end
    checks++; if (flags_o !== last_f) begin errors++; $display("FAIL mid_reset_flags: got %b want %b", flags_o, last_f); end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (valid_o) nvalid++;
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL mid_reset_no_valid: got %0d valids want 0", nvalid); end
    test_add();
  endtask

  initial begin
    test_reset();
    test_add();
    test_vectors();
    test_busy_start();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
